// File: rtl/mult_share_ctrl_pkg.sv
// Shared types for the multiplier-sharing controller.
//   SIZE_DEF       : default operand width
//   PROD           : MSB index of a default-width product (2*SIZE_DEF-1)
//   operand_t      : default-width operand
//   product_t      : default-width full product
//   mshare_state_t : controller FSM states
package mult_pkg;

    localparam int SIZE_DEF = 16;
    localparam int PROD     = 2*SIZE_DEF - 1;

    typedef logic [SIZE_DEF-1:0] operand_t;
    typedef logic [PROD:0]       product_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } mshare_state_t;

endpackage

// File: rtl/mult_share_ctrl_if.sv
// Client-side bus of the shared multiplier.
//   req_valid/req_ready : per-requester request handshake (ready one-hot or zero)
//   req_a/req_b         : packed operands, requester k at [k*SIZE +: SIZE]
//   rsp_valid/rsp_ready : product handshake
//   rsp_id/rsp_p        : owner index and unsigned 2*SIZE product
// master = requesters/consumer side, slave = controller side.
interface mult_share_ctrl_if #(
    parameter int NREQ = 4,
    parameter int SIZE = mult_pkg::SIZE_DEF
);
    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ*SIZE-1:0]    req_a;
    logic [NREQ*SIZE-1:0]    req_b;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [$clog2(NREQ)-1:0] rsp_id;
    logic [2*SIZE-1:0]       rsp_p;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_p
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_p
    );
endinterface

// File: rtl/mult_share_ctrl_array_mult.sv
// Unsigned carry-save array multiplier with LAT output register stages.
//   clk : clock
//   a,b : SIZE-bit operands, must stay stable while the result settles
//   p   : 2*SIZE-bit product, valid LAT cycles after a/b settle
module array_mult #(
    parameter int SIZE = 16,
    parameter int LAT  = 1
) (
    input  logic              clk,
    input  logic [SIZE-1:0]   a,
    input  logic [SIZE-1:0]   b,
    output logic [2*SIZE-1:0] p
);
    localparam int PW = 2*SIZE;

    logic [PW-1:0] p_comb;

    // Each row folds one partial product into a sum/carry pair without
    // propagating carries; a single adder resolves the pair at the end.
    // Carries out of the top bit are dropped: the true product fits PW bits.
    always_comb begin
        logic [PW-1:0] s, c, pp, s_n;
        s   = '0;
        c   = '0;
        pp  = '0;
        s_n = '0;
        for (int i = 0; i < SIZE; i++) begin
            pp  = b[i] ? (PW'(a) << i) : '0;
            s_n = s ^ c ^ pp;
            c   = ((s & c) | (s & pp) | (c & pp)) << 1;
            s   = s_n;
        end
        p_comb = s + c;
    end

    logic [PW-1:0] pipe [LAT];

    always_ff @(posedge clk) begin
        pipe[0] <= p_comb;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end

    assign p = pipe[LAT-1];
endmodule

// File: rtl/mult_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req : request vector
//   ptr : index of the last winner; search starts at ptr+1 and wraps
//   gnt : one-hot grant (zero when no request)
//   idx : encoded winner index (0 when no request)
//   hit : at least one request present
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] idx,
    output logic                    hit
);
    localparam int IDW = $clog2(NREQ);

    always_comb begin
        int k;
        k   = 0;
        gnt = '0;
        idx = '0;
        hit = 1'b0;
        // offsets 1..NREQ visit every port once, the last one being ptr itself
        for (int i = 1; i <= NREQ; i++) begin
            k = (int'(ptr) + i) % NREQ;
            if (!hit && req[k]) begin
                hit    = 1'b1;
                gnt[k] = 1'b1;
                idx    = IDW'(k);
            end
        end
    end
endmodule

// File: rtl/mult_share_ctrl.sv
// Shares one array multiplier among NREQ requesters.
// Round-robin grant in IDLE, operands held for LAT+1 cycles in EXEC, product
// presented in RESP until the consumer takes it. One operation in flight.
//   clk, rst : clock, synchronous active-high reset
//   bus      : mult_share_ctrl_if.slave (request and response handshakes)
//   busy     : high whenever the FSM is not IDLE
//   chk_err  : only with MULT_SHARE_CHECK_EN; one-cycle pulse in the first
//              RESP cycle when the array product differs from a behavioural
//              multiply. Observational only.
module mult_share_ctrl
    import mult_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int SIZE = SIZE_DEF,
    parameter int LAT  = 1
) (
    input  logic                clk,
    input  logic                rst,
    mult_share_ctrl_if.slave    bus,
    output logic                busy
`ifdef MULT_SHARE_CHECK_EN
    ,
    output logic                chk_err
`endif
);
    localparam int IDW = $clog2(NREQ);
    localparam int PW  = 2*SIZE;
    localparam int CW  = $clog2(LAT+1);

    mshare_state_t   state;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  op_id;
    logic [SIZE-1:0] op_a, op_b;
    logic [CW-1:0]   cnt;
    logic            rsp_valid_q;
    logic [IDW-1:0]  rsp_id_q;
    logic [PW-1:0]   rsp_p_q;

    logic [NREQ-1:0] win_gnt;
    logic [IDW-1:0]  win_idx;
    logic            win_hit;
    logic [PW-1:0]   mult_p;
    logic            exec_last;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req (bus.req_valid),
        .ptr (rr_ptr),
        .gnt (win_gnt),
        .idx (win_idx),
        .hit (win_hit)
    );

    array_mult #(.SIZE(SIZE), .LAT(LAT)) u_mult (
        .clk (clk),
        .a   (op_a),
        .b   (op_b),
        .p   (mult_p)
    );

    assign exec_last = (state == EXEC) && (cnt == CW'(LAT));

    // Grant is offered only in IDLE; masked during reset so no requester
    // believes it was accepted by a cycle that is about to be discarded.
    assign bus.req_ready = (state == IDLE && !rst) ? win_gnt : '0;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_p     = rsp_p_q;
    assign busy          = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= IDW'(NREQ-1);
            op_id       <= '0;
            op_a        <= '0;
            op_b        <= '0;
            cnt         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_p_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_hit) begin
                        op_a   <= bus.req_a[int'(win_idx)*SIZE +: SIZE];
                        op_b   <= bus.req_b[int'(win_idx)*SIZE +: SIZE];
                        op_id  <= win_idx;
                        rr_ptr <= win_idx;
                        cnt    <= '0;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    // cnt 0..LAT: LAT register stages plus one settle cycle
                    if (exec_last) begin
                        rsp_p_q     <= mult_p;
                        rsp_id_q    <= op_id;
                        rsp_valid_q <= 1'b1;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MULT_SHARE_CHECK_EN
    logic [PW-1:0] chk_p;
    logic          chk_stb;

    always_ff @(posedge clk) begin
        if (rst) begin
            chk_p   <= '0;
            chk_stb <= 1'b0;
        end else begin
            chk_stb <= exec_last;
            if (exec_last) chk_p <= PW'(op_a) * PW'(op_b);
        end
    end

    assign chk_err = chk_stb && (chk_p != rsp_p_q);
`endif
endmodule

// File: tb/tb_mult_share_ctrl.sv
// Self-checking bench for mult_share_ctrl: directed vector table, multi-cycle
// corner sequences (arbitration order, backpressure, reset mid-op) and a
// randomized run against a queue-based reference model.
// Build with MULT_SHARE_CHECK_EN defined to also watch chk_err.
module tb_mult_share_ctrl;
    import mult_pkg::*;

    localparam int NREQ = 4;
    localparam int SIZE = SIZE_DEF;
    localparam int LAT  = 1;
    localparam int PW   = 2*SIZE;
    localparam int NOPS = 5000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
`ifdef MULT_SHARE_CHECK_EN
    logic chk_err;
`endif

    int ntests = 0;
    int nfail  = 0;
    int cyc    = 0;
    int last   = NREQ-1;

    mult_share_ctrl_if #(.NREQ(NREQ), .SIZE(SIZE)) bus ();

    mult_share_ctrl #(.NREQ(NREQ), .SIZE(SIZE), .LAT(LAT)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .busy    (busy)
`ifdef MULT_SHARE_CHECK_EN
        ,
        .chk_err (chk_err)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", ntests);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            if (nfail <= 40) $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int k, input operand_t a, input operand_t b);
        bus.req_a[k*SIZE +: SIZE] = a;
        bus.req_b[k*SIZE +: SIZE] = b;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        repeat (2) step();
        rst  = 1'b0;
        last = NREQ-1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, " req_ready"}, bus.req_ready, '0);
        chk({tag, " rsp_valid"}, bus.rsp_valid, '0);
        chk({tag, " rsp_id"},    bus.rsp_id,    '0);
        chk({tag, " rsp_p"},     bus.rsp_p,     '0);
        chk({tag, " busy"},      busy,          '0);
    endtask

    // Returns at a negedge with rsp_valid high, or ok=0 after the bound.
    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_single(input string name, input int id, input operand_t a,
                             input operand_t b, input product_t p);
        int g;
        bit ok;
        step();
        set_op(id, a, b);
        bus.req_valid = NREQ'(1) << id;
        @(negedge clk);
        chk({name, " grant"}, bus.req_ready, NREQ'(1) << id);
        g = cyc;
        step();
        bus.req_valid = '0;
        wait_rsp(ok);
        chk({name, " rsp seen"}, ok, 1);
        chk({name, " latency"}, cyc - g, LAT + 2);
        chk({name, " rsp_id"}, bus.rsp_id, id);
        chk({name, " rsp_p"}, bus.rsp_p, p);
        last = id;
    endtask

    // Reference arbitration: among valid ports, the one at the smallest
    // circular distance after the last winner.
    function automatic int rr_pick(input logic [NREQ-1:0] v, input int lst);
        int best  = -1;
        int bestd = NREQ;
        for (int k = 0; k < NREQ; k++) begin
            int d;
            d = (k - lst - 1 + 2*NREQ) % NREQ;
            if (v[k] && d < bestd) begin
                best  = k;
                bestd = d;
            end
        end
        return best;
    endfunction

    function automatic operand_t rnd_op();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            default: return operand_t'($urandom);
        endcase
    endfunction

    typedef struct {
        int       id;
        operand_t a;
        operand_t b;
        product_t p;
    } vec_t;

    typedef struct {
        int       id;
        product_t p;
        int       gc;
    } exp_t;

    initial begin
        vec_t     vt[8];
        product_t e2[NREQ];
        int       order[5];
        int       gcnt, rcnt, gprev;
        bit       ok;
        // random-phase state
        logic [NREQ-1:0] pv;
        operand_t        pa[NREQ], pb[NREQ];
        exp_t            q[$];
        exp_t            e;
        logic [NREQ-1:0] eg;
        int              acc, w, ops, rcv;
        bit              inflight, seen;

        vt[0] = '{0, 16'd3,     16'd5,     32'd15};
        vt[1] = '{2, 16'hFFFF,  16'hFFFF,  32'hFFFE0001};
        vt[2] = '{1, 16'h0000,  16'hABCD,  32'h00000000};
        vt[3] = '{3, 16'hFFFF,  16'h0001,  32'h0000FFFF};
        vt[4] = '{0, 16'h8000,  16'h8000,  32'h40000000};
        vt[5] = '{1, 16'h0100,  16'h0100,  32'h00010000};
        vt[6] = '{3, 16'h00FF,  16'h0101,  32'h0000FFFF};
        vt[7] = '{2, 16'h1234,  16'h0010,  32'h00012340};

        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;
        rst           = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("in reset");
        step();
        rst = 1'b0;
        @(negedge clk);
        check_reset("after reset");

        // directed single operations
        for (int i = 0; i < 8; i++)
            do_single($sformatf("vec%0d", i), vt[i].id, vt[i].a, vt[i].b, vt[i].p);

        // all ports requesting continuously: order 0,1,2,3,0 at LAT+3 spacing
        do_reset();
        for (int k = 0; k < NREQ; k++) begin
            set_op(k, operand_t'(16'h1000 + k*16'h111), operand_t'(3 + k*7));
            e2[k] = product_t'(16'h1000 + k*16'h111) * product_t'(3 + k*7);
        end
        order = '{0, 1, 2, 3, 0};
        gcnt = 0;
        rcnt = 0;
        gprev = 0;
        bus.req_valid = '1;
        for (int n = 0; n < 80 && rcnt < 5; n++) begin
            @(negedge clk);
            if (bus.req_ready != '0) begin
                if (gcnt < 5) begin
                    chk("rr order", bus.req_ready, NREQ'(1) << order[gcnt]);
                    if (gcnt > 0) chk("rr spacing", cyc - gprev, LAT + 3);
                end
                gprev = cyc;
                gcnt++;
            end
            if (bus.rsp_valid && rcnt < 5) begin
                chk("rr rsp_id", bus.rsp_id, order[rcnt]);
                chk("rr rsp_p", bus.rsp_p, e2[order[rcnt]]);
                rcnt++;
            end
            step();
            if (gcnt >= 5) bus.req_valid = '0;
        end
        chk("rr responses", rcnt, 5);
        chk("rr grants", gcnt, 5);
        last = 0;

        // backpressure: response held stable, no grants, busy high
        step();
        step();
        bus.rsp_ready = 1'b0;
        set_op(1, 16'd7, 16'd9);
        bus.req_valid = 4'b0010;
        @(negedge clk);
        chk("bp grant", bus.req_ready, 4'b0010);
        step();
        bus.req_valid = '0;
        wait_rsp(ok);
        chk("bp rsp seen", ok, 1);
        step();
        bus.req_valid = '1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            chk("bp hold", {bus.rsp_valid, busy, bus.rsp_id, bus.rsp_p},
                {1'b1, 1'b1, 2'd1, 32'd63});
            chk("bp req_ready", bus.req_ready, '0);
            step();
        end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        step();
        step();
        last = 1;

        // reset during EXEC discards the op and restarts arbitration at port 0
        set_op(2, 16'd3, 16'd3);
        bus.req_valid = 4'b0100;
        @(negedge clk);
        chk("rst grant2", bus.req_ready, 4'b0100);
        step();
        bus.req_valid = '0;
        rst = 1'b1;
        @(negedge clk);
        chk("rst busy exec", busy, 1);
        step();
        for (int k = 0; k < NREQ; k++) set_op(k, operand_t'(10 + k), operand_t'(20 + k));
        bus.req_valid = '1;
        @(negedge clk);
        check_reset("mid-op reset");
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst next grant", bus.req_ready, 4'b0001);
        chk("rst no stale rsp", bus.rsp_valid, 0);
        step();
        bus.req_valid = '0;
        wait_rsp(ok);
        chk("rst rsp seen", ok, 1);
        chk("rst rsp_id", bus.rsp_id, 0);
        chk("rst rsp_p", bus.rsp_p, 32'd200);

        // randomized run against the reference model
        do_reset();
        pv = '0;
        for (int k = 0; k < NREQ; k++) begin
            pa[k] = '0;
            pb[k] = '0;
        end
        acc = -1;
        ops = 0;
        rcv = 0;
        inflight = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 60000; c++) begin
            if (ops >= NOPS && q.size() == 0 && pv == '0) break;
            step();
            if (acc >= 0) begin
                pv[acc] = 1'b0;
                acc = -1;
            end
            if (ops < NOPS)
                for (int k = 0; k < NREQ; k++)
                    if (!pv[k] && $urandom_range(0, 3) == 0) begin
                        pv[k] = 1'b1;
                        pa[k] = rnd_op();
                        pb[k] = rnd_op();
                    end
            for (int k = 0; k < NREQ; k++) set_op(k, pa[k], pb[k]);
            bus.req_valid = pv;
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            w  = inflight ? -1 : rr_pick(pv, last);
            eg = (w >= 0) ? (NREQ'(1) << w) : '0;
            chk("rnd grant", bus.req_ready, eg);
            if (w >= 0) begin
                e.id = w;
                e.p  = product_t'(pa[w]) * product_t'(pb[w]);
                e.gc = cyc;
                q.push_back(e);
                inflight = 1'b1;
                last = w;
                acc = w;
                ops++;
            end
            chk("rnd rsp without op", bus.rsp_valid && (q.size() == 0), 0);
            if (bus.rsp_valid && q.size() != 0) begin
                if (!seen) begin
                    chk("rnd latency", cyc - q[0].gc, LAT + 2);
                    seen = 1'b1;
                end
                if (bus.rsp_ready) begin
                    chk("rnd rsp_id", bus.rsp_id, q[0].id);
                    chk("rnd rsp_p", bus.rsp_p, q[0].p);
                    void'(q.pop_front());
                    inflight = 1'b0;
                    seen = 1'b0;
                    rcv++;
                end
            end
`ifdef MULT_SHARE_CHECK_EN
            chk("rnd chk_err", chk_err, 0);
`endif
        end
        chk("rnd lost responses", q.size(), 0);
        chk("rnd response count", rcv, ops);
        chk("rnd ops completed", ops >= NOPS, 1);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
